// File: rtl/rs232_protocol_host.sv
// Initiator side of the ASCII UART/Wishbone bridge protocol: sends "?r"/"?w" hex frames and parses hex read replies.
// Optional reply watchdog enabled by defining RS232_HOST_TIMEOUT_EN.
module rs232_protocol_host #(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDRESS_WIDTH-1:0] req_adr,
   input  logic [DATA_WIDTH-1:0]    req_dat,
   output logic                     rsp_valid,
   output logic [DATA_WIDTH-1:0]    rsp_dat,
   output logic                     rsp_err,
   output logic [7:0]               tx_byte,
   output logic                     tx_byte_valid,
   input  logic                     tx_ready,
   input  logic [7:0]               rx_byte,
   input  logic                     rx_byte_valid
);

   localparam int AD   = ADDRESS_WIDTH / 4;
   localparam int DD   = DATA_WIDTH / 4;
   localparam int MAXD = (AD > DD) ? AD : DD;
   localparam int CW   = $clog2(MAXD + 1);

   if ((ADDRESS_WIDTH % 4) != 0 || ADDRESS_WIDTH < 4) begin : g_bad_adr_width
      $error("ADDRESS_WIDTH must be a positive multiple of 4");
   end
   if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4) begin : g_bad_dat_width
      $error("DATA_WIDTH must be a positive multiple of 4");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_CMD, S_ADR, S_DAT, S_WAIT_RSP, S_DONE
   } state_t;

   state_t                   state;
   logic                     we_q;
   logic [ADDRESS_WIDTH-1:0] adr_sh;
   logic [DATA_WIDTH-1:0]    dat_sh;
   logic [CW-1:0]            dig_cnt;
   logic                     tx_fire;
   logic [4:0]               rx_dec;
   logic                     rx_ws;
   logic                     timeout_hit;
   logic [DATA_WIDTH-1:0]    rx_next;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : (8'h57 + {4'h0, n});
   endfunction

   // {is_hex, nibble}; letters of either case carry value low_nibble + 9
   function automatic logic [4:0] hex_val(input logic [7:0] b);
      if (b >= 8'h30 && b <= 8'h39)
         return {1'b1, b[3:0]};
      else if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46))
         return {1'b1, b[3:0] + 4'd9};
      else
         return 5'b0_0000;
   endfunction

   assign tx_fire = tx_byte_valid & tx_ready;
   assign rx_dec  = hex_val(rx_byte);
   assign rx_ws   = (rx_byte == 8'h0A) || (rx_byte == 8'h0D) || (rx_byte == 8'h20);
   assign rx_next = (dat_sh << 4) | DATA_WIDTH'(rx_dec[3:0]);

`ifdef RS232_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         to_cnt <= '0;
      else if (state != S_WAIT_RSP || rx_byte_valid)
         to_cnt <= '0;
      else if (!timeout_hit)
         to_cnt <= to_cnt + TW'(1);
   end

   assign timeout_hit = (state == S_WAIT_RSP) && !rx_byte_valid &&
                        (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: every register here, datapath included, is cleared by the async reset so an abandoned
   // frame leaves no residue; all state updates use non-blocking assignments.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= S_IDLE;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_dat       <= '0;
         rsp_err       <= 1'b0;
         tx_byte       <= 8'h00;
         tx_byte_valid <= 1'b0;
         we_q          <= 1'b0;
         adr_sh        <= '0;
         dat_sh        <= '0;
         dig_cnt       <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready     <= 1'b0;
                  we_q          <= req_we;
                  adr_sh        <= req_adr;
                  dat_sh        <= req_dat;
                  tx_byte       <= 8'h3F;
                  tx_byte_valid <= 1'b1;
                  state         <= S_SYNC;
               end
            end
            S_SYNC: if (tx_fire) begin
               tx_byte <= we_q ? 8'h77 : 8'h72;
               state   <= S_CMD;
            end
            S_CMD: if (tx_fire) begin
               tx_byte <= hex_char(adr_sh[ADDRESS_WIDTH-1 -: 4]);
               adr_sh  <= adr_sh << 4;
               dig_cnt <= '0;
               state   <= S_ADR;
            end
            S_ADR: if (tx_fire) begin
               if (dig_cnt == CW'(AD - 1)) begin
                  dig_cnt <= '0;
                  if (we_q) begin
                     tx_byte <= hex_char(dat_sh[DATA_WIDTH-1 -: 4]);
                     dat_sh  <= dat_sh << 4;
                     state   <= S_DAT;
                  end else begin
                     tx_byte       <= 8'h00;
                     tx_byte_valid <= 1'b0;
                     dat_sh        <= '0;
                     state         <= S_WAIT_RSP;
                  end
               end else begin
                  tx_byte <= hex_char(adr_sh[ADDRESS_WIDTH-1 -: 4]);
                  adr_sh  <= adr_sh << 4;
                  dig_cnt <= dig_cnt + CW'(1);
               end
            end
            S_DAT: if (tx_fire) begin
               if (dig_cnt == CW'(DD - 1)) begin
                  tx_byte       <= 8'h00;
                  tx_byte_valid <= 1'b0;
                  rsp_valid     <= 1'b1;
                  rsp_dat       <= '0;
                  rsp_err       <= 1'b0;
                  state         <= S_DONE;
               end else begin
                  tx_byte <= hex_char(dat_sh[DATA_WIDTH-1 -: 4]);
                  dat_sh  <= dat_sh << 4;
                  dig_cnt <= dig_cnt + CW'(1);
               end
            end
            S_WAIT_RSP: begin
               if (rx_byte_valid) begin
                  if (rx_dec[4]) begin
                     dat_sh <= rx_next;
                     if (dig_cnt == CW'(DD - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_dat   <= rx_next;
                        rsp_err   <= 1'b0;
                        state     <= S_DONE;
                     end else begin
                        dig_cnt <= dig_cnt + CW'(1);
                     end
                  end else if (!rx_ws) begin
                     rsp_valid <= 1'b1;
                     rsp_dat   <= '0;
                     rsp_err   <= 1'b1;
                     state     <= S_DONE;
                  end
               end else if (timeout_hit) begin
                  rsp_valid <= 1'b1;
                  rsp_dat   <= '0;
                  rsp_err   <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               rsp_dat   <= '0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_protocol_host.sv
// Directed scoreboard bench for rs232_protocol_host: expected TX bytes and responses are queued at
// request time and compared as the DUT transfers them.
module tb_rs232_protocol_host;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [15:0] req_adr = 16'h0000;
   logic [7:0]  req_dat = 8'h00;
   logic        rsp_valid;
   logic [7:0]  rsp_dat;
   logic        rsp_err;
   logic [7:0]  tx_byte;
   logic        tx_byte_valid;
   logic        tx_ready = 1'b1;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_byte_valid = 1'b0;

   typedef struct packed {
      logic [7:0] dat;
      logic       err;
   } rsp_t;

   logic [7:0] exp_tx[$];
   rsp_t       exp_rsp[$];
   int         tx_cycs[$];
   int         cyc = 0;
   int         rsp_cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;

   rs232_protocol_host #(
      .ADDRESS_WIDTH (16),
      .DATA_WIDTH    (8),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_adr      (req_adr),
      .req_dat      (req_dat),
      .rsp_valid    (rsp_valid),
      .rsp_dat      (rsp_dat),
      .rsp_err      (rsp_err),
      .tx_byte      (tx_byte),
      .tx_byte_valid(tx_byte_valid),
      .tx_ready     (tx_ready),
      .rx_byte      (rx_byte),
      .rx_byte_valid(rx_byte_valid)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc++;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Scoreboard monitor: inputs change just after posedge, so the negedge view is what the next edge samples.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (tx_byte_valid && tx_ready) begin
            tx_cycs.push_back(cyc);
            if (exp_tx.size() == 0) check("tx_extra", 32'(tx_byte_valid), 32'd0);
            else                    check("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
         end
         if (rsp_valid) begin
            rsp_t e;
            rsp_cyc = cyc;
            if (exp_rsp.size() == 0) begin
               check("rsp_extra", 32'(rsp_valid), 32'd0);
            end else begin
               e = exp_rsp.pop_front();
               check("rsp_dat", 32'(rsp_dat), 32'(e.dat));
               check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
         end
      end
   end

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
   endtask

   task automatic push_rsp(input logic [7:0] dat, input logic err);
      rsp_t e;
      e.dat = dat;
      e.err = err;
      exp_rsp.push_back(e);
   endtask

   // Called and returns at the posedge+#1 phase; request is accepted at the final posedge.
   task automatic do_req(input logic we, input logic [15:0] adr, input logic [7:0] dat);
      int n;
      req_valid = 1'b1;
      req_we    = we;
      req_adr   = adr;
      req_dat   = dat;
      n = 0;
      @(negedge clk_i);
      while (!req_ready && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
      @(posedge clk_i); #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_adr   = 16'h0000;
      req_dat   = 8'h00;
   endtask

   task automatic wait_tx_drain(input int budget);
      int n;
      n = 0;
      while (exp_tx.size() != 0 && n < budget) begin
         @(posedge clk_i); #1;
         n++;
      end
      if (exp_tx.size() != 0) check("tx_drain_wait", 32'(exp_tx.size()), 32'd0);
   endtask

   task automatic wait_rsp(input int budget);
      int n;
      n = 0;
      while (exp_rsp.size() != 0 && n < budget) begin
         @(posedge clk_i); #1;
         n++;
      end
      if (exp_rsp.size() != 0) check("rsp_wait", 32'(exp_rsp.size()), 32'd0);
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_byte       = b;
      rx_byte_valid = 1'b1;
      @(posedge clk_i); #1;
      rx_byte_valid = 1'b0;
      rx_byte       = 8'h00;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_dat"}, 32'(rsp_dat), 32'd0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      check({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
      check({tag, "_tx_valid"}, 32'(tx_byte_valid), 32'd0);
   endtask

   initial begin
      int n;

      // Reset state
      repeat (3) @(negedge clk_i);
      check_idle_outputs("reset");
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      check("idle_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk_i); #1;

      // 1: read 0x0000, reply "0a"
      push_str("?r0000");
      push_rsp(8'h0A, 1'b0);
      tx_cycs.delete();
      do_req(1'b0, 16'h0000, 8'h00);
      @(negedge clk_i);
      check("first_tx_valid", 32'(tx_byte_valid), 32'd1);
      check("busy_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk_i); #1;
      wait_tx_drain(40);
      check("rd_tx_count", 32'(tx_cycs.size()), 32'd6);
      if (tx_cycs.size() == 6) check("rd_tx_back_to_back", 32'(tx_cycs[5] - tx_cycs[0]), 32'd5);
      send_rx(8'h30);
      send_rx(8'h61);
      wait_rsp(20);

      // 2: write 0x0000 <- 0x15
      push_str("?w000015");
      push_rsp(8'h00, 1'b0);
      tx_cycs.delete();
      do_req(1'b1, 16'h0000, 8'h15);
      wait_tx_drain(40);
      wait_rsp(20);
      check("wr_tx_count", 32'(tx_cycs.size()), 32'd8);
      if (tx_cycs.size() != 0) check("wr_rsp_latency", 32'(rsp_cyc - tx_cycs[$]), 32'd1);
      @(negedge clk_i);
      check("wr_back_idle_ready", 32'(req_ready), 32'd1);
      check("wr_rsp_one_cycle", 32'(rsp_valid), 32'd0);
      @(posedge clk_i); #1;

      // 3: read 0xBEEF with a 5-cycle stall on the second address digit and an echo byte during TX
      push_str("?rbeef");
      push_rsp(8'hA5, 1'b0);
      do_req(1'b0, 16'hBEEF, 8'h00);
      n = 0;
      @(negedge clk_i);
      while (!(tx_byte_valid && tx_byte == 8'h62) && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check("saw_first_digit", 32'(tx_byte), 32'h62);
      @(posedge clk_i); #1;
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rx_byte       = 8'h33;
         rx_byte_valid = (i == 1);
         @(negedge clk_i);
         check("stall_tx_byte", 32'(tx_byte), 32'h65);
         check("stall_tx_valid", 32'(tx_byte_valid), 32'd1);
         @(posedge clk_i); #1;
      end
      rx_byte_valid = 1'b0;
      rx_byte       = 8'h00;
      tx_ready      = 1'b1;
      wait_tx_drain(40);
      send_rx(8'h0D);
      send_rx(8'h41);
      send_rx(8'h35);
      wait_rsp(20);

      // 4: malformed reply, then a normal read with ignorable whitespace
      push_str("?r1234");
      push_rsp(8'h00, 1'b1);
      do_req(1'b0, 16'h1234, 8'h00);
      wait_tx_drain(40);
      send_rx(8'h78);
      wait_rsp(20);
      push_str("?r00ff");
      push_rsp(8'hFF, 1'b0);
      do_req(1'b0, 16'h00FF, 8'h00);
      wait_tx_drain(40);
      send_rx(8'h20);
      send_rx(8'h66);
      send_rx(8'h0A);
      send_rx(8'h46);
      wait_rsp(20);

      // 5: reset after "?w00" has been sent
      push_str("?w00");
      do_req(1'b1, 16'h0012, 8'h34);
      wait_tx_drain(40);
      rst_i = 1'b1;
      #1;
      check_idle_outputs("midframe_rst");
      @(negedge clk_i);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check("rst_tx_queue", 32'(exp_tx.size()), 32'd0);
      push_str("?r00c3");
      push_rsp(8'h7E, 1'b0);
      do_req(1'b0, 16'h00C3, 8'h00);
      wait_tx_drain(40);
      send_rx(8'h37);
      send_rx(8'h65);
      wait_rsp(20);

`ifdef RS232_HOST_TIMEOUT_EN
      // 6: reply watchdog, plain and restarted by a byte on the 15th cycle
      push_str("?r0001");
      push_rsp(8'h00, 1'b1);
      tx_cycs.delete();
      do_req(1'b0, 16'h0001, 8'h00);
      wait_tx_drain(40);
      wait_rsp(40);
      if (tx_cycs.size() != 0) check("timeout_latency", 32'(rsp_cyc - tx_cycs[$]), 32'd17);
      push_str("?r0002");
      push_rsp(8'h00, 1'b1);
      tx_cycs.delete();
      do_req(1'b0, 16'h0002, 8'h00);
      wait_tx_drain(40);
      repeat (14) @(posedge clk_i);
      #1;
      send_rx(8'h20);
      wait_rsp(60);
      if (tx_cycs.size() != 0) check("timeout_restart_latency", 32'(rsp_cyc - tx_cycs[$]), 32'd32);
`endif

      repeat (3) @(posedge clk_i);
      check("end_tx_queue", 32'(exp_tx.size()), 32'd0);
      check("end_rsp_queue", 32'(exp_rsp.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
